// File: rtl/systolic_pkg.sv
// Shared types and defaults for the output-stationary systolic array
// controller and the array top.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    FLUSH,
    DRAIN,
    DONE
  } state_t;

  localparam int DEF_N        = 4;
  localparam int DEF_K_MAX    = 64;
  localparam int DEF_PIPE_LAT = 4;

  // Operands need 2(N-1) hops to reach the far corner PE, then PIPE_LAT to settle.
  function automatic int flush_cycles(input int n, input int pipe_lat);
    return 2 * (n - 1) + pipe_lat;
  endfunction

endpackage

// File: rtl/skew_gen.sv
// Per-lane operand skew: lane LANE reads element t-LANE while
// LANE <= t < LANE+k_len during FEED, otherwise idles at address 0.
module skew_gen #(
  parameter int T_W    = 7,
  parameter int KL_W   = 7,
  parameter int ADDR_W = 6,
  parameter int LANE   = 0
) (
  input  logic              feed,
  input  logic [T_W-1:0]    t,
  input  logic [KL_W-1:0]   k_len,
  output logic              en,
  output logic [ADDR_W-1:0] addr
);

  localparam int EW = ((T_W > KL_W) ? T_W : KL_W) + 1;

  logic [EW-1:0] t_w;
  logic [EW-1:0] lo;
  logic [EW-1:0] hi;

  always_comb begin
    t_w  = EW'(t);
    lo   = EW'(LANE);
    hi   = EW'(LANE) + EW'(k_len);
    en   = feed && (t_w >= lo) && (t_w < hi);
    addr = en ? ADDR_W'(t_w - lo) : '0;
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Job sequencer for an NxN output-stationary systolic array: clear, skewed
// operand feed, pipeline flush, row drain over valid/ready, done pulse.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int K_MAX    = DEF_K_MAX,
  parameter int PIPE_LAT = DEF_PIPE_LAT,
  parameter int ADDR_W   = $clog2(K_MAX),
  parameter int KL_W     = $clog2(K_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [KL_W-1:0]       k_len,
  output logic                  busy,
  output logic                  done,
  output logic                  pe_acc_clr,
  output logic [N-1:0]          a_rd_en,
  output logic [N*ADDR_W-1:0]   a_rd_addr,
  output logic [N-1:0]          b_rd_en,
  output logic [N*ADDR_W-1:0]   b_rd_addr,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [$clog2(N)-1:0]  res_row,
  output logic                  res_last
);

  localparam int T_W       = $clog2(K_MAX + N - 1);
  localparam int CW        = T_W + KL_W;
  localparam int FLUSH_CYC = flush_cycles(N, PIPE_LAT);
  localparam int FL_W      = $clog2(FLUSH_CYC + 1);
  localparam int RW        = $clog2(N);

  state_t          state;
  state_t          state_nx;
  logic [KL_W-1:0] k_lat;
  logic [KL_W-1:0] k_clamped;
  logic [T_W-1:0]  t_cnt;
  logic [FL_W-1:0] flush_cnt;
  logic [RW-1:0]   row_cnt;
  logic            feed;
  logic            feed_last;
  logic            flush_last;
  logic            drain_last;

  assign k_clamped  = (k_len > KL_W'(K_MAX)) ? KL_W'(K_MAX) : k_len;
  assign feed_last  = (CW'(t_cnt) == CW'(k_lat) + CW'(N - 2));
  assign flush_last = (flush_cnt == FL_W'(FLUSH_CYC - 1));
  assign drain_last = res_ready && (row_cnt == RW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (k_len == '0) ? DONE : CLEAR;
      CLEAR:   state_nx = FEED;
      FEED:    if (feed_last) state_nx = FLUSH;
      FLUSH:   if (flush_last) state_nx = DRAIN;
      DRAIN:   if (drain_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Counters sit at zero outside their own phase so each phase starts clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_lat     <= '0;
      t_cnt     <= '0;
      flush_cnt <= '0;
      row_cnt   <= '0;
    end else begin
      if (state == IDLE && start) k_lat <= k_clamped;
      t_cnt     <= (state == FEED && !feed_last) ? t_cnt + 1'b1 : '0;
      flush_cnt <= (state == FLUSH && !flush_last) ? flush_cnt + 1'b1 : '0;
      if (state == DRAIN) begin
        if (res_ready) row_cnt <= drain_last ? '0 : row_cnt + 1'b1;
      end else begin
        row_cnt <= '0;
      end
    end
  end

  always_comb begin
    busy       = (state != IDLE);
    done       = (state == DONE);
    pe_acc_clr = (state == CLEAR);
    feed       = (state == FEED);
    res_valid  = (state == DRAIN);
    res_row    = (state == DRAIN) ? row_cnt : '0;
    res_last   = (state == DRAIN) && (row_cnt == RW'(N - 1));
  end

  // Row and column skews are identical, so A and B lanes share one generator type.
  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_gen #(
      .T_W(T_W), .KL_W(KL_W), .ADDR_W(ADDR_W), .LANE(i)
    ) u_a_skew (
      .feed(feed), .t(t_cnt), .k_len(k_lat),
      .en(a_rd_en[i]), .addr(a_rd_addr[i*ADDR_W +: ADDR_W])
    );
    skew_gen #(
      .T_W(T_W), .KL_W(KL_W), .ADDR_W(ADDR_W), .LANE(i)
    ) u_b_skew (
      .feed(feed), .t(t_cnt), .k_len(k_lat),
      .en(b_rd_en[i]), .addr(b_rd_addr[i*ADDR_W +: ADDR_W])
    );
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: per-cycle comparison of every output against a
// schedule model derived from the job timeline, over table and random jobs.
module tb_systolic_ctrl;

  localparam int N        = 4;
  localparam int K_MAX    = 64;
  localparam int PIPE_LAT = 4;
  localparam int AW       = 6;
  localparam int KW       = 7;
  localparam int RW       = 2;
  localparam int FL       = 2 * (N - 1) + PIPE_LAT;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [KW-1:0] k_len;
  logic          busy;
  logic          done;
  logic          pe_acc_clr;
  logic [N-1:0]  a_rd_en;
  logic [N*AW-1:0] a_rd_addr;
  logic [N-1:0]  b_rd_en;
  logic [N*AW-1:0] b_rd_addr;
  logic          res_valid;
  logic          res_ready;
  logic [RW-1:0] res_row;
  logic          res_last;

  always #5 clk = ~clk;

  systolic_ctrl #(.N(N), .K_MAX(K_MAX), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .busy(busy), .done(done), .pe_acc_clr(pe_acc_clr),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_row(res_row), .res_last(res_last)
  );

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          clr;
    logic [N-1:0]  a_en;
    logic [N*AW-1:0] a_addr;
    logic [N-1:0]  b_en;
    logic [N*AW-1:0] b_addr;
    logic          valid;
    logic [RW-1:0] row;
    logic          last;
  } obs_t;

  typedef struct {
    int k;
    int ready_mode;
    int pulse_c;
    int rst_c;
    int exp_done;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  obs_t act;

  always_comb begin
    act        = '0;
    act.busy   = busy;
    act.done   = done;
    act.clr    = pe_acc_clr;
    act.a_en   = a_rd_en;
    act.a_addr = a_rd_addr;
    act.b_en   = b_rd_en;
    act.b_addr = b_rd_addr;
    act.valid  = res_valid;
    act.row    = res_row;
    act.last   = res_last;
  end

  // Expected outputs at cycle c of a job (c=1 is the cycle after start is sampled),
  // given the number of rows the consumer has accepted so far.
  function automatic obs_t model(input int c, input int ke, input int r, input int db);
    obs_t e;
    int   t;
    e = '0;
    if ((ke == 0 && c == 1) || r == N) begin
      e.busy = 1'b1;
      e.done = 1'b1;
    end else if (c == 1) begin
      e.busy = 1'b1;
      e.clr  = 1'b1;
    end else if (c < db) begin
      e.busy = 1'b1;
      t = c - 2;
      for (int i = 0; i < N; i++) begin
        if (t >= i && t < i + ke) begin
          e.a_en[i] = 1'b1;
          e.b_en[i] = 1'b1;
          e.a_addr[i*AW +: AW] = AW'(t - i);
          e.b_addr[i*AW +: AW] = AW'(t - i);
        end
      end
    end else begin
      e.busy  = 1'b1;
      e.valid = 1'b1;
      e.row   = RW'(r);
      e.last  = (r == N - 1);
    end
    return e;
  endfunction

  function automatic logic readyFor(input int mode, input int j);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (j % 3 == 0);
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic checkOutput(input string nm, input int c, input obs_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    int    ke;
    int    db;
    int    r;
    int    done_c;
    bit    fin;
    bit    aborted;
    obs_t  e;
    string nm;
    ke      = (v.k > K_MAX) ? K_MAX : v.k;
    db      = ke + N + 1 + FL;
    r       = 0;
    fin     = 1'b0;
    aborted = 1'b0;
    done_c  = -1;
    nm      = $sformatf("job%0d_k%0d", idx, v.k);
    start   = 1'b1;
    k_len   = KW'(v.k);
    for (int c = 1; c <= 600 && !fin; c++) begin
      @(negedge clk);
      start = (c == v.pulse_c);
      k_len = KW'($urandom_range(0, 127));
      e = model(c, ke, r, db);
      checkOutput(nm, c, e);
      if (act.done && done_c < 0) done_c = c;
      if (e.valid) res_ready = readyFor(v.ready_mode, c - db);
      else         res_ready = (v.ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (e.valid && res_ready) r++;
      if (e.done) fin = 1'b1;
      if (c == v.rst_c) begin
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        checkOutput({nm, "_rst"}, c + 1, '0);
        aborted = 1'b1;
        fin     = 1'b1;
      end
    end
    if (!fin) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s timeout: done not reached, rows accepted %0d required %0d", nm, r, N);
    end else if (!aborted) begin
      @(negedge clk);
      start = 1'b0;
      checkOutput({nm, "_idle"}, -1, '0);
      if (v.exp_done != 0) begin
        tests++;
        if (done_c != v.exp_done) begin
          fails++;
          $display("[TB] FAIL %s done_cycle: got %0d expected %0d", nm, done_c, v.exp_done);
        end
      end
    end
  endtask

  vec_t vecs[$];

  initial begin
    vec_t rv;
    // k, ready_mode, start pulse cycle, reset cycle, expected done cycle
    vecs.push_back('{8,   0, 0,  0, 27});
    vecs.push_back('{1,   0, 0,  0, 20});
    vecs.push_back('{0,   0, 0,  0, 1});
    vecs.push_back('{8,   1, 0,  0, 33});
    vecs.push_back('{6,   0, 5,  0, 25});
    vecs.push_back('{5,   0, 0, 12, 0});
    vecs.push_back('{3,   0, 0,  0, 22});
    vecs.push_back('{64,  0, 0,  0, 83});
    vecs.push_back('{100, 0, 0,  0, 83});
    vecs.push_back('{2,   1, 0,  0, 27});

    rst       = 1'b1;
    start     = 1'b1;
    k_len     = KW'(8);
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset", 0, '0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_idle", 0, '0);

    foreach (vecs[i]) applyStimulus(i, vecs[i]);

    for (int j = 0; j < 6; j++) begin
      rv.k          = $urandom_range(0, 70);
      rv.ready_mode = 2;
      rv.pulse_c    = $urandom_range(0, 20);
      rv.rst_c      = 0;
      rv.exp_done   = 0;
      applyStimulus(100 + j, rv);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencer for an N×N output-stationary systolic array of floating-point MAC PEs. On `start` it clears the PE accumulators, then streams skewed read enables and addresses to the per-row A buffers and per-column B buffers for `k_len` inner-product steps. It waits for the array pipeline to flush, drains the N result rows through a valid/ready port, and pulses `done`. It sits between the host/command logic and the PE array plus its operand buffers.

## Interface
Parameters:
- `N`, 4: array dimension (rows = columns).
- `K_MAX`, 64: maximum inner dimension; buffer depth.
- `PIPE_LAT`, 4: cycles from an operand reaching a PE until its accumulated value is stable (multiplier plus adder latency).
- `ADDR_W`, `$clog2(K_MAX)`: buffer address width.
- `KL_W`, `$clog2(K_MAX+1)`: width of `k_len`.

Ports:
- `clk`, in, 1: the single clock. All logic is on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: starts a job. Sampled only in IDLE.
- `k_len`, in, KL_W: inner dimension. Captured with `start`. Legal range is 0..K_MAX.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse at job end.
- `pe_acc_clr`, out, 1: clears all PE accumulators.
- `a_rd_en`, out, N: per-row A buffer read enable.
- `a_rd_addr`, out, N*ADDR_W: per-row A read address. Row i occupies bits [i*ADDR_W +: ADDR_W].
- `b_rd_en`, out, N: per-column B buffer read enable.
- `b_rd_addr`, out, N*ADDR_W: per-column B read address. Same packing as `a_rd_addr`.
- `res_valid`, out, 1: result row `res_row` is presented.
- `res_ready`, in, 1: consumer accepts the row.
- `res_row`, out, `$clog2(N)`: selects the array row to output.
- `res_last`, out, 1: high together with `res_valid` for row N-1.

## Operation
- FSM states: IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE.
- IDLE:
  - `start`=1 and `k_len`≠0: latch `k_len` and go to CLEAR.
  - `start`=1 and `k_len`=0: go directly to DONE. No clear, feed or drain occurs.
  - `k_len`>K_MAX is clamped to K_MAX.
- CLEAR: lasts one cycle. `pe_acc_clr`=1, then go to FEED.
- FEED:
  - Counter t runs from 0 to k_len+N-2, so FEED lasts k_len+N-1 cycles.
  - Lane i (row i of A, column i of B): enable = (i ≤ t < i+k_len). Address = t−i when enabled, otherwise 0.
  - Row and column skews are identical.
- FLUSH: waits 2(N−1)+PIPE_LAT cycles, which lets operands propagate to PE(N−1,N−1) and its accumulation settle.
- DRAIN:
  - `res_row` starts at 0 and `res_valid`=1.
  - The row index advances on each cycle where `res_valid`&`res_ready`. It holds while `res_ready`=0.
  - After row N−1 is accepted, go to DONE.
- DONE: lasts one cycle with `done`=1, then go to IDLE. `busy` drops in the following cycle.
- `start` while `busy`: ignored, with no queuing.
- `rst` in any state: return to IDLE the next edge. Any job in progress is abandoned.
- Reset value of every output is 0: `busy`, `done`, `pe_acc_clr`, all enables and addresses, `res_valid`, `res_row`, `res_last`.

## Timing
- All outputs are registered: they are a Moore decode of the state and counters.
- `start` is sampled at edge 0.
  - CLEAR occupies cycle 1.
  - FEED occupies cycles 2..k_len+N.
  - FLUSH occupies the next 2(N−1)+PIPE_LAT cycles.
  - DRAIN takes at least N cycles.
  - DONE takes 1 cycle.
- Minimum latency from `start` to `done` is 2 + k_len + N−1 + 2(N−1) + PIPE_LAT + N cycles.
- Buffer read data is assumed to arrive one cycle after its enable; that cycle is covered by FLUSH.
- `res_row` and `res_valid` must stay stable until the handshake completes.

## Structure
- Package `systolic_pkg` holds:
  - `state_t` enum.
  - Default `N`, `K_MAX` and `PIPE_LAT` localparams.
  - A `flush_cycles(N, PIPE_LAT)` function, shared with the array top.
- Sub-module `skew_gen`: combinational, purely per lane. Maps (t, k_len, lane index) to (en, addr). It is instantiated 2N times via generate.

## Test plan
- N=4, PIPE_LAT=4, k_len=8, `res_ready` tied to 1:
  - `pe_acc_clr` is high at cycle 1 only.
  - `a_rd_en[0]` is high in cycles 2–9; `a_rd_en[3]` is high in cycles 5–12.
  - `res_valid` is high in cycles 23–26; `done` is high in cycle 27.
- k_len=1 → each lane is enabled for exactly one cycle with addr 0. Lane i fires at cycle 2+i.
- k_len=0 → `done` at cycle 1. No `pe_acc_clr`, `rd_en` or `res_valid` ever asserted.
- DRAIN with `res_ready` toggling 1,0,0,1,… → `res_row` holds during stalls. Rows 0..3 are each accepted exactly once, and `res_last` appears only with row 3.
- `start` pulsed during FEED → ignored. `rst` during FLUSH → next cycle all outputs are 0 and the state is IDLE. A new `start` then runs a full job normally.
- k_len=K_MAX=64 → the last address on lane 3 is 63 at cycle 68. The address never wraps.
